// File: rtl/control_unit.sv
// control_unit: four-cycle FETCH/DECODE/EXEC/WB sequencer for the 4-bit-opcode CPU.
// Define HALT_EN to make opcode F park the FSM in HALT until reset; otherwise F is a NOP.
module control_unit (
    input  logic       clock,
    input  logic       reset,
    input  logic       flag,
    input  logic [3:0] opcode,
    output logic       inst_wr,
    output logic       decoder_en,
    output logic [1:0] pc_op,
    output logic       reg_en,
    output logic       rD_wr,
    output logic       imm_en,
    output logic       adrs_ctrl,
    output logic       mem_rd,
    output logic       mem_wr
);
    localparam logic [3:0] OP_NOP = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4, OP_XOR = 4'h5, OP_NOT = 4'h6, OP_SHL = 4'h7;
    localparam logic [3:0] OP_SHR = 4'h8, OP_LDI = 4'h9, OP_LOAD = 4'hA, OP_STORE = 4'hB;
    localparam logic [3:0] OP_JMP = 4'hC, OP_JZ = 4'hD, OP_CMP = 4'hE, OP_HLT = 4'hF;
    localparam logic [1:0] PC_HOLD = 2'b00, PC_INC = 2'b01, PC_LOAD = 2'b10, PC_CLR = 2'b11;

    typedef enum logic [2:0] {S_RST, FETCH, DECODE, EXEC, WB, HALT} state_t;
    state_t state, next_state;

    logic alu_op;
    assign alu_op = (opcode >= OP_ADD && opcode <= OP_SHR);

    always_ff @(posedge clock or negedge reset)
        if (!reset) state <= S_RST;
        else        state <= next_state;

    always_comb begin
        next_state = state;
        inst_wr    = 1'b0;
        decoder_en = 1'b0;
        pc_op      = PC_HOLD;
        reg_en     = 1'b0;
        rD_wr      = 1'b0;
        imm_en     = 1'b0;
        adrs_ctrl  = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        case (state)
            S_RST: begin
                pc_op      = PC_CLR;
                next_state = FETCH;
            end
            FETCH: begin
                mem_rd     = 1'b1;
                inst_wr    = 1'b1;
                next_state = DECODE;
            end
            DECODE: begin
                decoder_en = 1'b1;
                pc_op      = PC_INC;
                reg_en     = 1'b1;
                next_state = EXEC;
            end
            EXEC: begin
                next_state = WB;
                case (opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
                    OP_NOT, OP_SHL, OP_SHR, OP_CMP: reg_en = 1'b1;
                    OP_LDI: imm_en = 1'b1;
                    OP_LOAD: begin
                        adrs_ctrl = 1'b1;
                        mem_rd    = 1'b1;
                    end
                    OP_STORE: begin
                        adrs_ctrl = 1'b1;
                        mem_wr    = 1'b1;
                        reg_en    = 1'b1;
                    end
                    OP_JMP: pc_op = PC_LOAD;
                    OP_JZ:  pc_op = flag ? PC_LOAD : PC_HOLD;
`ifdef HALT_EN
                    OP_HLT: next_state = HALT;
`else
                    OP_HLT: ;
`endif
                    default: ;
                endcase
            end
            WB: begin
                next_state = FETCH;
                rD_wr      = alu_op || opcode == OP_LDI || opcode == OP_LOAD;
                reg_en     = alu_op;
                imm_en     = opcode == OP_LDI;
                adrs_ctrl  = opcode == OP_LOAD;
                mem_rd     = opcode == OP_LOAD;
            end
            HALT: next_state = HALT;
            default: next_state = S_RST;
        endcase
    end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed vector table, corner sequences and random instruction stream
// checked against a rule-level model of control_unit (HALT_EN-aware).
module tb_control_unit;
    logic       clock = 1'b0;
    logic       reset, flag;
    logic [3:0] opcode;
    logic       inst_wr, decoder_en, reg_en, rD_wr, imm_en, adrs_ctrl, mem_rd, mem_wr;
    logic [1:0] pc_op;

    int n_tests = 0;
    int n_fail  = 0;

    control_unit dut (
        .clock(clock), .reset(reset), .flag(flag), .opcode(opcode),
        .inst_wr(inst_wr), .decoder_en(decoder_en), .pc_op(pc_op), .reg_en(reg_en),
        .rD_wr(rD_wr), .imm_en(imm_en), .adrs_ctrl(adrs_ctrl), .mem_rd(mem_rd), .mem_wr(mem_wr)
    );

    always #5 clock = ~clock;

    // packed view: {inst_wr, decoder_en, pc_op[1:0], reg_en, rD_wr, imm_en, adrs_ctrl, mem_rd, mem_wr}
    logic [9:0] outs;
    assign outs = {inst_wr, decoder_en, pc_op, reg_en, rD_wr, imm_en, adrs_ctrl, mem_rd, mem_wr};

    localparam logic [9:0] V_RST = 10'b0011000000;
    localparam logic [9:0] V_FET = 10'b1000000010;
    localparam logic [9:0] V_DEC = 10'b0101100000;

    typedef struct {
        string      name;
        logic [3:0] op;
        logic       fl;
        logic [9:0] exec_exp;
        logic [9:0] wb_exp;
    } vec_t;

    // phases: 0 reset, 1 fetch, 2 decode, 3 exec, 4 writeback, 5 halted
    function automatic logic [9:0] model(int ph, logic [3:0] op, logic fl);
        logic iw, de, re, rw, ie, ac, mr, mw;
        logic [1:0] pc;
        int o;
        o = int'(op);
        {iw, de, re, rw, ie, ac, mr, mw} = '0;
        pc = 2'd0;
        if (ph == 0) pc = 2'd3;
        if (ph == 1) begin iw = 1; mr = 1; end
        if (ph == 2) begin de = 1; pc = 2'd1; re = 1; end
        if (ph == 3) begin
            if ((o >= 1 && o <= 8) || o == 14) re = 1;
            if (o == 9) ie = 1;
            if (o == 10) begin ac = 1; mr = 1; end
            if (o == 11) begin ac = 1; mw = 1; re = 1; end
            if (o == 12 || (o == 13 && fl)) pc = 2'd2;
        end
        if (ph == 4) begin
            if (o >= 1 && o <= 8) begin rw = 1; re = 1; end
            if (o == 9) begin rw = 1; ie = 1; end
            if (o == 10) begin rw = 1; ac = 1; mr = 1; end
        end
        return {iw, de, pc, re, rw, ie, ac, mr, mw};
    endfunction

    task automatic chk(string name, logic [9:0] exp);
        n_tests++;
        if (outs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, outs, exp);
        end
    endtask

    // entered at the negedge where the DUT sits in FETCH; leaves at the next FETCH negedge
    task automatic run(string nm, logic [3:0] op, logic fl, logic [9:0] ee, logic [9:0] we);
        flag = fl;
        chk({nm, " fetch"}, V_FET);
        opcode = op;
        @(negedge clock); chk({nm, " decode"}, V_DEC);
        @(negedge clock); chk({nm, " exec"}, ee);
        @(negedge clock); chk({nm, " wb"}, we);
        @(negedge clock);
    endtask

    task automatic pulse_reset(string nm);
        #2 reset = 1'b0;
        #1 chk({nm, " async reset"}, V_RST);
        @(negedge clock); chk({nm, " held reset"}, V_RST);
        reset = 1'b1;
        @(negedge clock); chk({nm, " fetch after reset"}, V_FET);
    endtask

    vec_t vecs[$];

    initial begin
        vecs.push_back('{"NOP",   4'h0, 1'b0, 10'b0000000000, 10'b0000000000});
        vecs.push_back('{"ADD",   4'h1, 1'b1, 10'b0000100000, 10'b0000110000});
        vecs.push_back('{"SHR",   4'h8, 1'b0, 10'b0000100000, 10'b0000110000});
        vecs.push_back('{"LDI",   4'h9, 1'b0, 10'b0000001000, 10'b0000011000});
        vecs.push_back('{"LOAD",  4'hA, 1'b0, 10'b0000000110, 10'b0000010110});
        vecs.push_back('{"STORE", 4'hB, 1'b0, 10'b0000100101, 10'b0000000000});
        vecs.push_back('{"JMP",   4'hC, 1'b0, 10'b0010000000, 10'b0000000000});
        vecs.push_back('{"JZ t",  4'hD, 1'b1, 10'b0010000000, 10'b0000000000});
        vecs.push_back('{"JZ nt", 4'hD, 1'b0, 10'b0000000000, 10'b0000000000});
        vecs.push_back('{"CMP",   4'hE, 1'b1, 10'b0000100000, 10'b0000000000});
`ifndef HALT_EN
        vecs.push_back('{"F nop", 4'hF, 1'b1, 10'b0000000000, 10'b0000000000});
`endif
        reset = 1'b0; opcode = 4'h0; flag = 1'b0;
        #3 chk("reset before edge", V_RST);
        #4 chk("reset after edge", V_RST);
        @(negedge clock); #2 reset = 1'b1;
        @(negedge clock); chk("first fetch", V_FET);

        foreach (vecs[i]) run(vecs[i].name, vecs[i].op, vecs[i].fl, vecs[i].exec_exp, vecs[i].wb_exp);

        // reset in the middle of a LOAD writeback aborts it
        opcode = 4'hA;
        @(negedge clock); @(negedge clock); @(negedge clock);
        chk("mid load wb", 10'b0000010110);
        pulse_reset("mid load");

        // randomized stream: opcode garbage during FETCH, flag noise every phase
        for (int n = 0; n < 60; n++) begin
            logic [3:0] op;
`ifdef HALT_EN
            op = 4'($urandom_range(0, 14));
`else
            op = 4'($urandom_range(0, 15));
`endif
            opcode = 4'($urandom); flag = 1'($urandom);
            #1 chk("rnd fetch", model(1, op, flag));
            opcode = op;
            for (int ph = 2; ph <= 4; ph++) begin
                @(negedge clock); flag = 1'($urandom);
                #1 chk($sformatf("rnd op%0h ph%0d", op, ph), model(ph, op, flag));
                n_tests++;
                if (mem_rd && mem_wr) begin
                    n_fail++;
                    $display("FAIL rnd strobes: mem_rd=%b mem_wr=%b required not both 1", mem_rd, mem_wr);
                end
            end
            @(negedge clock);
        end

`ifdef HALT_EN
        flag = 1'b1;
        chk("halt fetch", V_FET);
        opcode = 4'hF;
        @(negedge clock); chk("halt decode", V_DEC);
        @(negedge clock); chk("halt exec", 10'b0000000000);
        for (int k = 0; k < 4; k++) begin
            opcode = 4'($urandom); flag = 1'($urandom);
            @(negedge clock); chk("halted", 10'b0000000000);
        end
        pulse_reset("halt exit");
        opcode = 4'h1;
        @(negedge clock); chk("post halt decode", V_DEC);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
